// File: rtl/wb_stream_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_pkg
// Description : Wishbone CTI/BTE encodings and FIFO sizing helpers shared by
//               the stream reader controller and its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_stream_pkg;

    // Wishbone B4 cycle type identifiers
    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    // Wishbone B4 burst type extensions
    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } wb_bte_e;

    localparam int FIFO_AW_DEFAULT = 4;

    function automatic int fifo_depth(input int aw);
        return 1 << aw;
    endfunction

    // One extra bit so a completely full FIFO is representable.
    function automatic int fifo_cnt_width(input int aw);
        return aw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_stream_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_fifo_ram
// Description : DEPTH x DW storage, one synchronous write port, one
//               asynchronous read port, no reset.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stream_fifo_ram #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/wb_stream_reader_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_stream_reader_fifo
// Description : First-word fall-through stream FIFO with sticky underflow flag
//               and optional stale-data timeout (WB_STREAM_FIFO_TIMEOUT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_stream_reader_fifo
    import wb_stream_pkg::*;
#(
    parameter int WB_DW       = 32,
    parameter int FIFO_AW     = 4,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_ni,
    input  logic [WB_DW-1:0]     stream_s_data_i,
    input  logic                 stream_s_valid_i,
    output logic                 stream_s_ready_o,
    output logic [WB_DW-1:0]     fifo_d,
    input  logic                 fifo_rd,
    output logic [FIFO_AW:0]     fifo_cnt,
    input  logic                 clear_i,
    output logic                 rd_err_o,
    output logic                 fifo_timeout_o
);

    localparam int DEPTH = fifo_depth(FIFO_AW);
    localparam int CW    = fifo_cnt_width(FIFO_AW);

    generate
        if (FIFO_AW < 1) begin : g_bad_aw
            $error("wb_stream_reader_fifo: FIFO_AW must be at least 1");
        end
    endgenerate

    logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q,    cnt_d;
    logic               rd_err_q, rd_err_d;

    logic wr_en;
    logic rd_en;
    logic rd_empty;

    assign stream_s_ready_o = (cnt_q < CW'(DEPTH));
    assign wr_en            = stream_s_valid_i & stream_s_ready_o;
    assign rd_en            = fifo_rd & (cnt_q != '0);
    assign rd_empty         = fifo_rd & (cnt_q == '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rd_err_d = rd_err_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            rd_err_d = 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            end
            if (wr_en && !rd_en) begin
                cnt_d = cnt_q + CW'(1);
            end else if (rd_en && !wr_en) begin
                cnt_d = cnt_q - CW'(1);
            end
            if (rd_empty) begin
                rd_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rd_err_q <= rd_err_d;
        end
    end

    // A write coinciding with a flush is dropped, so keep it out of memory too.
    wb_stream_fifo_ram #(
        .DW (WB_DW),
        .AW (FIFO_AW)
    ) u_ram (
        .clk_i   (wb_clk_i),
        .we_i    (wr_en & ~clear_i),
        .waddr_i (wr_ptr_q),
        .wdata_i (stream_s_data_i),
        .raddr_i (rd_ptr_q),
        .rdata_o (fifo_d)
    );

    assign fifo_cnt = cnt_q;
    assign rd_err_o = rd_err_q;

`ifdef WB_STREAM_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (wr_en || rd_en || clear_i || (cnt_q == '0)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMAX) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign fifo_timeout_o = (tmo_cnt_q == TMAX) && (cnt_q != '0);
`else
    assign fifo_timeout_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/wb_stream_reader_fifo.md
WB_STREAM_READER_FIFO -- requirements
Module: wb_stream_reader_fifo

Interface
REQ-001 The block SHALL provide parameter WB_DW, default 32, meaning data word width in bits.
REQ-002 The block SHALL provide parameter FIFO_AW, default 4, meaning log2 of FIFO depth (DEPTH = 2**FIFO_AW); FIFO_AW < 1 is a compile-time error.
REQ-003 The block SHALL provide parameter TIMEOUT_CYC, default 256, meaning the idle-cycle threshold for the timeout flag.
REQ-004 The block SHALL provide port wb_clk_i, input, 1 bit, the single clock.
REQ-005 The block SHALL provide port wb_rst_ni, input, 1 bit, asynchronous active-low reset.
REQ-006 The block SHALL provide port stream_s_data_i, input, WB_DW bits, the upstream stream word.
REQ-007 The block SHALL provide port stream_s_valid_i, input, 1 bit, upstream word valid.
REQ-008 The block SHALL provide port stream_s_ready_o, output, 1 bit, FIFO accepts a word.
REQ-009 The block SHALL provide port fifo_d, output, WB_DW bits, the head word (first-word fall-through).
REQ-010 The block SHALL provide port fifo_rd, input, 1 bit, pop head word.
REQ-011 The block SHALL provide port fifo_cnt, output, FIFO_AW+1 bits, current occupancy.
REQ-012 The block SHALL provide port clear_i, input, 1 bit, synchronous flush.
REQ-013 The block SHALL provide port rd_err_o, output, 1 bit, sticky pop-while-empty flag.
REQ-014 The block SHALL provide port fifo_timeout_o, output, 1 bit, stale-data indication.

Function
REQ-015 stream_s_ready_o SHALL equal (fifo_cnt < DEPTH), combinational from registered count only.
REQ-016 A write SHALL occur when stream_s_valid_i & stream_s_ready_o; the word is stored at wr_ptr and wr_ptr increments.
REQ-017 A pop SHALL occur when fifo_rd & (fifo_cnt != 0); rd_ptr increments.
REQ-018 Pointers SHALL be FIFO_AW bits and wrap modulo DEPTH without special handling.
REQ-019 fifo_cnt SHALL update as +1 on write only, -1 on pop only, unchanged on both or neither, in the cycle after the event.
REQ-020 fifo_d SHALL present mem[rd_ptr] combinationally; a written word is visible on fifo_d one cycle after acceptance when FIFO was empty.
REQ-021 fifo_d content SHALL be don't-care while fifo_cnt == 0.
REQ-022 When full, a simultaneous pop SHALL succeed and the write SHALL NOT (ready is low); ready rises the next cycle.
REQ-023 When empty, a simultaneous write SHALL succeed, the pop SHALL be ignored, and rd_err_o SHALL set.
REQ-024 fifo_rd while fifo_cnt == 0 SHALL set rd_err_o, which stays high until clear_i or reset.
REQ-025 clear_i SHALL zero pointers, fifo_cnt and rd_err_o next cycle, overriding any write or pop in the same cycle; memory contents are not cleared.

Reset
REQ-026 On wb_rst_ni low, asynchronously: wr_ptr=0, rd_ptr=0, fifo_cnt=0, rd_err_o=0, fifo_timeout_o=0, timeout counter=0; stream_s_ready_o therefore 1.
REQ-027 Reset mid-operation SHALL discard all stored words; deassertion is synchronised externally.

Configuration
REQ-028 Macro WB_STREAM_FIFO_TIMEOUT_EN SHALL compile in the timeout counter.
REQ-029 With the macro: counter clears on write, pop, clear_i, or fifo_cnt == 0; otherwise increments, saturating at TIMEOUT_CYC-1.
REQ-030 With the macro: fifo_timeout_o SHALL be high while the counter equals TIMEOUT_CYC-1 and fifo_cnt != 0, dropping the cycle after the next write, pop or clear.
REQ-031 Without the macro: fifo_timeout_o SHALL be constant 0 and no counter logic exists.

Structure
REQ-032 Package wb_stream_pkg SHALL hold the CTI/BTE encodings and the FIFO depth/count width helper constants shared with the stream reader controller.
REQ-033 Storage SHALL be a sub-module wb_stream_fifo_ram: DEPTH x WB_DW, one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-034 Reset, then write 0xA0..0xAF (16 words, FIFO_AW=4) back-to-back -> fifo_cnt=16, stream_s_ready_o=0, 17th word held off.
REQ-035 Full FIFO, valid high with 0xBB plus fifo_rd one cycle -> fifo_cnt=15, fifo_d=0xA1, ready=1 next cycle, 0xBB accepted after.
REQ-036 Empty FIFO, write 0x55 with fifo_rd same cycle -> fifo_cnt=1, fifo_d=0x55, rd_err_o=1.
REQ-037 Write 20 words, pop 20 in interleaved pattern -> data order preserved across pointer wrap, fifo_cnt returns 0.
REQ-038 Macro on, TIMEOUT_CYC=8: write 1 word, idle -> fifo_timeout_o high 8 cycles after write; fifo_rd -> low next cycle.
REQ-039 fifo_cnt=5, clear_i with simultaneous write -> fifo_cnt=0, rd_err_o=0, the write dropped.
